rle_pixel_decoder: RTL and testbench
====================================

Name: rle_pixel_decoder

Overview:
Downstream stage of the display file fetch unit. Consumes the fetched byte stream and expands CD-i run-length coded lines (RL7, and RL3 when compiled in) into one pixel per output transfer. Output feeds the CLUT/plane mixer stage. Enforces line length: runs are truncated at end of line, and "run to end of line" fills the remaining pixels.

Parameters:
LINE_W, 10, width of pixel counter and line_pixels.

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active-low
start_line  input  1  pulse; begin new line, abort any run in progress
line_pixels  input  LINE_W  pixels per line; sampled on start_line
rl3  input  1  1=RL3 coding, 0=RL7; sampled on start_line
in  pixelstream.sink  -  byte stream from fetch unit (write=valid, pixel=byte, strobe=consume)
out  pixelstream.source  -  decoded pixels (write=valid, pixel[7:0], strobe=consume)
line_done  output  1  high while the line is complete and no more bytes are taken

Behaviour:
- Reset (reset_n=0 at clk edge): state LINE_END, out.write=0, out.pixel=0, in.strobe=0, line_done=1, pixel counter=0, run counter=0.
- Input handshake: a byte transfers in any cycle where in.write && in.strobe. in.strobe is combinational. It is asserted only in CMD or LEN state, with no start_line and reset_n=1.
- Output handshake: out.write/out.pixel are registered. A pixel transfers in any cycle where out.write && out.strobe. The pixel holds stable while out.write=1 and out.strobe=0. Sustained throughput is 1 pixel/clk.
- States: CMD, LEN, EMIT, LINE_END.
- start_line (highest priority after reset):
  - latch line_pixels and rl3.
  - remaining := line_pixels.
  - drop any pending output (out.write<=0).
  - next state CMD, or LINE_END if line_pixels==0.
- CMD, byte b accepted:
  - RL7: colour={1'b0,b[6:0]}.
  - RL3: colour pair A=b[6:4], B=b[2:0], each output as {5'b0,c}.
  - b[7]=0: single pixel (RL7) or single pair (RL3); run:=1; go EMIT.
  - b[7]=1: go LEN.
- LEN, byte n accepted:
  - n!=0: run:=n (pixels in RL7, pairs in RL3).
  - n==0: run := fill to end of line.
  - Go EMIT.
- EMIT:
  - Present one pixel per transfer; RL3 alternates A,B per pair.
  - Each transfer decrements remaining.
  - Decrement run after each pixel (RL7) or after each B (RL3).
  - remaining reaches 0 -> LINE_END immediately, even mid-run or mid-pair. Excess run is discarded.
  - run reaches 0 with remaining>0 -> CMD.
- LINE_END: in.strobe=0, line_done=1. Holds until start_line.
- No bubble between runs: the next CMD byte may be accepted in the same cycle as the last pixel of a run leaves, if out.strobe=1.
- Arithmetic: remaining is LINE_W bits, run is 8 bits, no wrap. Counters saturate at 0 and never underflow.
- Empty input: state holds, out.write falls after the last pixel leaves.
- Simultaneous start_line and in.write: the byte is not consumed.

Optional Feature:
RLE_RL3_EN
- Defined: RL3 decoding is supported as described.
- Undefined: rl3 input is ignored, all lines decode as RL7, and the RL3 pair logic is not synthesised.

Decomposition:
- Package rle_pkg holds:
  - state enum rle_state_e (CMD, LEN, EMIT, LINE_END).
  - constant RUN_FILL=8'd0.
  - constant RUN_FLAG_BIT=7.
- Sub-module rle_out_reg: one-entry registered output holding register with valid/strobe handshake. Used for out.

Test Plan:
- line_pixels=4, RL7, bytes 0x05,0x06,0x07,0x08, out.strobe=1 -> pixels 05,06,07,08 on 4 consecutive cycles; line_done=1 after; in.strobe=0 for a 5th byte.
- line_pixels=10, RL7, bytes 0x83,0x03,0x85,0x00 -> 03,03,03 then 05 x7; line_done=1.
- line_pixels=5, RL7, bytes 0x81,0x09 -> 01 x5 (truncated); the following byte is not consumed.
- RLE_RL3_EN, rl3=1, line_pixels=6, bytes 0xA3 (run, A=2, B=3), 0x02, 0x15 -> 02,03,02,03,01,05.
- Backpressure: out.strobe toggles 1,0,0,1 during a run -> no pixel lost or duplicated; out.pixel stable while stalled.
- Abort: start_line (line_pixels=2) asserted mid-run after 2 of 9 pixels -> pending pixel dropped; next bytes 0x11,0x12 yield 11,12; reset_n=0 mid-run -> out.write=0, line_done=1 the next cycle.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length pixel decoder.
package rle_pkg;

  typedef enum logic [1:0] {
    CMD      = 2'd0,
    LEN      = 2'd1,
    EMIT     = 2'd2,
    LINE_END = 2'd3
  } rle_state_e;

  // A length byte of zero means "run to end of line".
  localparam logic [7:0] RUN_FILL     = 8'd0;
  localparam int         RUN_FLAG_BIT = 7;

  function automatic logic [7:0] rl3_pixel(input logic [2:0] c);
    return {5'b0, c};
  endfunction

endpackage

// File: rtl/pixelstream.sv
// Byte/pixel stream: write=valid, pixel=data, strobe=consume; a beat moves when write && strobe.
interface pixelstream;
  logic       write;
  logic [7:0] pixel;
  logic       strobe;

  modport source (output write, output pixel, input strobe);
  modport sink   (input write, input pixel, output strobe);
endinterface

// File: rtl/rle_out_reg.sv
// One-entry output holding register; data appears one cycle after load_i.
// Holds pixel stable while rdy_i is low; can_load_o allows a new load in the cycle the old one leaves.
module rle_out_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush_i,
  input  logic       load_i,
  input  logic [7:0] load_dat_i,
  input  logic       rdy_i,
  output logic       can_load_o,
  output logic       vld_o,
  output logic [7:0] dat_o
);

  logic       vld_q, vld_d;
  logic [7:0] dat_q, dat_d;

  assign can_load_o = !vld_q || rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d = 1'b1;
      dat_d = load_dat_i;
    end else if (rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      dat_q <= 8'd0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/rle_pixel_decoder.sv
// Expands RL7 (and RL3 when RLE_RL3_EN is defined) coded lines into one pixel per transfer,
// clipping runs at line end; registered output, 1 pixel/clk sustained, stalls on out.strobe=0.
module rle_pixel_decoder
  import rle_pkg::*;
#(
  parameter int LINE_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_line,
  input  logic [LINE_W-1:0] line_pixels,
  input  logic              rl3,
  pixelstream.sink          in,
  pixelstream.source        out,
  output logic              line_done
);

  rle_state_e        state_q, state_d;
  logic [LINE_W-1:0] remaining_q, remaining_d, rem_dec;
  logic [7:0]        run_q, run_d, col_q, col_d, byte_in, load_dat, out_dat;
  logic              load, can_load, flush, strobe_c, run_step, out_vld;

`ifdef RLE_RL3_EN
  logic       rl3_q, phase_b_q, phase_b_d;
  logic [2:0] colb_q, colb_d;
`else
  logic unused_rl3;
  assign unused_rl3 = rl3;
`endif

  assign byte_in = in.pixel;
  assign rem_dec = (remaining_q == '0) ? '0 : remaining_q - LINE_W'(1);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    run_d       = run_q;
    col_d       = col_q;
    load        = 1'b0;
    load_dat    = col_q;
    flush       = 1'b0;
    strobe_c    = 1'b0;
    run_step    = 1'b0;
`ifdef RLE_RL3_EN
    phase_b_d   = phase_b_q;
    colb_d      = colb_q;
`endif
    if (start_line) begin
      flush       = 1'b1;
      remaining_d = line_pixels;
      run_d       = 8'd0;
      state_d     = (line_pixels == '0) ? LINE_END : CMD;
`ifdef RLE_RL3_EN
      phase_b_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        CMD: begin
          // Literal bytes emit their first pixel straight away so single pixels stream back to back.
          strobe_c = can_load;
          if (in.write && can_load) begin
            col_d = {1'b0, byte_in[6:0]};
`ifdef RLE_RL3_EN
            if (rl3_q) begin
              col_d  = rl3_pixel(byte_in[6:4]);
              colb_d = byte_in[2:0];
            end
`endif
            if (byte_in[RUN_FLAG_BIT]) begin
              state_d = LEN;
            end else begin
              load        = 1'b1;
              load_dat    = col_d;
              remaining_d = rem_dec;
              state_d     = (rem_dec == '0) ? LINE_END : CMD;
`ifdef RLE_RL3_EN
              if (rl3_q && rem_dec != '0) begin
                run_d     = 8'd1;
                phase_b_d = 1'b1;
                state_d   = EMIT;
              end
`endif
            end
          end
        end
        LEN: begin
          strobe_c = 1'b1;
          if (in.write) begin
            run_d   = byte_in;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (can_load) begin
            load        = 1'b1;
            remaining_d = rem_dec;
            run_step    = 1'b1;
`ifdef RLE_RL3_EN
            if (rl3_q) begin
              run_step  = phase_b_q;
              phase_b_d = !phase_b_q;
              if (phase_b_q) load_dat = rl3_pixel(colb_q);
            end
`endif
            // run == RUN_FILL never counts down, so it lasts until the line is full.
            if (run_step && run_q != RUN_FILL) run_d = run_q - 8'd1;
            if (rem_dec == '0) state_d = LINE_END;
            else if (run_step && run_q == 8'd1) state_d = CMD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= LINE_END;
      remaining_q <= '0;
      run_q       <= 8'd0;
      col_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      run_q       <= run_d;
      col_q       <= col_d;
    end
  end

`ifdef RLE_RL3_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rl3_q     <= 1'b0;
      phase_b_q <= 1'b0;
      colb_q    <= 3'd0;
    end else begin
      if (start_line) rl3_q <= rl3;
      phase_b_q <= phase_b_d;
      colb_q    <= colb_d;
    end
  end
`endif

  rle_out_reg u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush),
    .load_i     (load),
    .load_dat_i (load_dat),
    .rdy_i      (out.strobe),
    .can_load_o (can_load),
    .vld_o      (out_vld),
    .dat_o      (out_dat)
  );

  assign out.write = out_vld;
  assign out.pixel = out_dat;
  assign in.strobe = strobe_c && reset_n;
  assign line_done = (state_q == LINE_END);

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Directed table-driven bench for rle_pixel_decoder plus abort/reset sequences.
module tb_rle_pixel_decoder;

  logic       clk = 1'b0;
  logic       reset_n, start_line, rl3, line_done;
  logic [9:0] line_pixels;

  pixelstream in_s ();
  pixelstream out_s ();

  always #5 clk = ~clk;

  rle_pixel_decoder #(.LINE_W(10)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_line  (start_line),
    .line_pixels (line_pixels),
    .rl3         (rl3),
    .in          (in_s),
    .out         (out_s),
    .line_done   (line_done)
  );

  typedef struct packed {
    logic [9:0]  lp;
    logic        r3;
    logic [7:0]  nb;
    logic [7:0]  ncons;
    logic [63:0] ib;     // first byte in [63:56]
    logic [7:0]  ne;
    logic [95:0] ex;     // first pixel in [95:88]
    logic [3:0]  st;     // out.strobe for cycle c is st[c%4]
    logic        consec;
  } vec_t;

  int   applied = 0;
  int   miscompares = 0;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] lp, input logic r3, input logic [7:0] nb,
                              input logic [7:0] ncons, input logic [63:0] ib, input logic [7:0] ne,
                              input logic [95:0] ex, input logic [3:0] st, input logic consec);
    vec_t v;
    v.lp = lp; v.r3 = r3; v.nb = nb; v.ncons = ncons; v.ib = ib;
    v.ne = ne; v.ex = ex; v.st = st; v.consec = consec;
    return v;
  endfunction

  task automatic cyc(input logic rn, input logic sl, input logic [9:0] lp, input logic r3,
                     input logic w, input logic [7:0] b, input logic st,
                     output logic it, output logic ot, output logic [7:0] px);
    @(negedge clk);
    reset_n     = rn;
    start_line  = sl;
    line_pixels = lp;
    rl3         = r3;
    in_s.write  = w;
    in_s.pixel  = b;
    out_s.strobe = st;
    #1;
    it = in_s.write && in_s.strobe;
    ot = out_s.write && out_s.strobe;
    px = out_s.pixel;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic       it, ot, st, w, held_v;
    logic [7:0] px, b, held;
    int         bi, oi, first, last;
    bi = 0; oi = 0; first = -1; last = -1; held_v = 1'b0; held = 8'd0;
    cyc(1'b1, 1'b1, v.lp, v.r3, 1'b0, 8'd0, 1'b1, it, ot, px);
    for (int c = 0; c < 40; c++) begin
      st = v.st[c % 4];
      w  = (bi < int'(v.nb));
      b  = 8'd0;
      if (w) b = v.ib[63 - 8*bi -: 8];
      cyc(1'b1, 1'b0, v.lp, v.r3, w, b, st, it, ot, px);
      if (held_v) check($sformatf("v%0d_stall_hold", idx), {out_s.write, px}, {1'b1, held});
      held_v = out_s.write && !st;
      held   = px;
      if (it) bi++;
      if (ot) begin
        if (oi < int'(v.ne)) check($sformatf("v%0d_pix%0d", idx, oi), px, v.ex[95 - 8*oi -: 8]);
        else check($sformatf("v%0d_extra_pixel", idx), oi, v.ne);
        if (first < 0) first = c;
        last = c;
        oi++;
      end
    end
    check($sformatf("v%0d_pixel_count", idx), oi, v.ne);
    check($sformatf("v%0d_bytes_consumed", idx), bi, v.ncons);
    check($sformatf("v%0d_line_done", idx), line_done, 1'b1);
    if (v.consec) check($sformatf("v%0d_back_to_back", idx), last - first, v.ne - 1);
  endtask

  initial begin
    logic       it, ot;
    logic [7:0] px;
    int         taken, bi, oi;

    reset_n = 1'b0; start_line = 1'b0; line_pixels = '0; rl3 = 1'b0;
    in_s.write = 1'b0; in_s.pixel = 8'd0; out_s.strobe = 1'b0;

    vecs[0] = mk(10'd4, 1'b0, 8'd5, 8'd4, {8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 24'h0},
                 8'd4, {8'h05, 8'h06, 8'h07, 8'h08, 64'h0}, 4'b1111, 1'b1);
    vecs[1] = mk(10'd10, 1'b0, 8'd4, 8'd4, {8'h83, 8'h03, 8'h85, 8'h00, 32'h0},
                 8'd10, {{3{8'h03}}, {7{8'h05}}, 16'h0}, 4'b1111, 1'b0);
    vecs[2] = mk(10'd5, 1'b0, 8'd3, 8'd2, {8'h81, 8'h09, 8'h42, 40'h0},
                 8'd5, {{5{8'h01}}, 56'h0}, 4'b1111, 1'b0);
    vecs[3] = mk(10'd6, 1'b0, 8'd2, 8'd2, {8'h85, 8'h00, 48'h0},
                 8'd6, {{6{8'h05}}, 48'h0}, 4'b1001, 1'b0);
    vecs[4] = mk(10'd0, 1'b0, 8'd1, 8'd0, {8'h05, 56'h0},
                 8'd0, 96'h0, 4'b1111, 1'b0);
    vecs[5] = mk(10'd2, 1'b0, 8'd3, 8'd3, {8'h7F, 8'h80, 8'h01, 40'h0},
                 8'd2, {8'h7F, 8'h00, 80'h0}, 4'b1111, 1'b0);
`ifdef RLE_RL3_EN
    vecs[6] = mk(10'd6, 1'b1, 8'd3, 8'd3, {8'hA3, 8'h02, 8'h15, 40'h0},
                 8'd6, {8'h02, 8'h03, 8'h02, 8'h03, 8'h01, 8'h05, 48'h0}, 4'b1111, 1'b0);
`else
    vecs[6] = mk(10'd2, 1'b1, 8'd2, 8'd2, {8'h23, 8'h15, 48'h0},
                 8'd2, {8'h23, 8'h15, 80'h0}, 4'b1111, 1'b0);
`endif

    // Reset state, with a byte offered and the sink ready.
    cyc(1'b0, 1'b0, 10'd4, 1'b0, 1'b1, 8'h05, 1'b1, it, ot, px);
    cyc(1'b0, 1'b0, 10'd4, 1'b0, 1'b1, 8'h05, 1'b1, it, ot, px);
    check("reset_in_strobe", it, 1'b0);
    check("reset_out_write", out_s.write, 1'b0);
    check("reset_out_pixel", px, 8'h00);
    check("reset_line_done", line_done, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort: restart mid-run after two of nine pixels.
    cyc(1'b1, 1'b1, 10'd9, 1'b0, 1'b0, 8'h00, 1'b1, it, ot, px);
    taken = 0; bi = 0;
    for (int c = 0; c < 30 && taken < 2; c++) begin
      cyc(1'b1, 1'b0, 10'd9, 1'b0, bi < 2, (bi == 0) ? 8'h87 : 8'h09, 1'b1, it, ot, px);
      if (it) bi++;
      if (ot) begin
        check($sformatf("abort_pre_pix%0d", taken), px, 8'h07);
        taken++;
      end
    end
    check("abort_pre_count", taken, 2);
    cyc(1'b1, 1'b1, 10'd2, 1'b0, 1'b1, 8'h11, 1'b0, it, ot, px);
    check("abort_start_no_consume", it, 1'b0);
    bi = 0; oi = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 1'b0, 10'd2, 1'b0, bi < 2, (bi == 0) ? 8'h11 : 8'h12, 1'b1, it, ot, px);
      if (c == 0) check("abort_pending_dropped", out_s.write, 1'b0);
      if (it) bi++;
      if (ot) begin
        check($sformatf("abort_pix%0d", oi), px, (oi == 0) ? 8'h11 : 8'h12);
        oi++;
      end
    end
    check("abort_pixel_count", oi, 2);
    check("abort_line_done", line_done, 1'b1);

    // Reset mid-run.
    cyc(1'b1, 1'b1, 10'd9, 1'b0, 1'b0, 8'h00, 1'b1, it, ot, px);
    taken = 0; bi = 0;
    for (int c = 0; c < 20 && taken < 3; c++) begin
      cyc(1'b1, 1'b0, 10'd9, 1'b0, bi < 2, (bi == 0) ? 8'h87 : 8'h00, 1'b1, it, ot, px);
      if (it) bi++;
      if (ot) taken++;
    end
    check("rst_mid_pre_count", taken, 3);
    cyc(1'b0, 1'b0, 10'd9, 1'b0, 1'b1, 8'h33, 1'b0, it, ot, px);
    check("rst_mid_in_strobe", it, 1'b0);
    cyc(1'b1, 1'b0, 10'd9, 1'b0, 1'b0, 8'h00, 1'b0, it, ot, px);
    check("rst_mid_out_write", out_s.write, 1'b0);
    check("rst_mid_out_pixel", px, 8'h00);
    check("rst_mid_line_done", line_done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
